// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv-stage serializer blocks.
package conv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   function automatic int ch_idx_w(input int num_ch);
      int w;
      w = $clog2(num_ch);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/vector_fifo.sv
// Synchronous FIFO of whole channel vectors; head word is valid whenever not empty.
module vector_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);

endmodule

// File: rtl/channel_serializer.sv
// Turns the valid-only parallel channel vector stream into a one-channel-per-beat
// valid/ready stream, buffering vectors in a small FIFO and flagging drops.
module channel_serializer
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int CH_W = ch_idx_w(NUM_CH),
   localparam int VW   = NUM_CH * DATA_WIDTH,
   localparam int LW   = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [VW-1:0]         x_in,
   input  logic                  x_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CH_W-1:0]       m_ch,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  overflow,
   input  logic                  clear_overflow,
   output logic [LW-1:0]         fifo_level
);

   ser_state_t       state;
   logic [VW-1:0]    head;
   logic [VW-1:0]    hold;
   logic             fifo_full;
   logic             fifo_empty;
   logic             hs;
   logic             fetch;
   logic             push;
   logic             drop;
   logic [CH_W-1:0]  ch_nxt;

   function automatic logic signed [DATA_WIDTH-1:0] sel_ch(input logic [VW-1:0]   vec,
                                                           input logic [CH_W-1:0] idx);
      return vec[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // A full FIFO still accepts a vector when the head leaves in the same cycle.
   always_comb begin
      hs     = m_valid & m_ready;
      fetch  = !fifo_empty && ((state == IDLE) || (hs && m_last));
      push   = x_valid && (!fifo_full || fetch);
      drop   = x_valid && fifo_full && !fetch;
      ch_nxt = m_ch + CH_W'(1);
   end

   vector_fifo #(
      .WIDTH (VW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (x_in),
      .pop     (fetch),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (fetch) hold <= head;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_ch     <= '0;
         m_last   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (drop)                overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;

         if (fetch) begin
            state   <= SEND;
            m_valid <= 1'b1;
            m_data  <= sel_ch(head, '0);
            m_ch    <= '0;
            m_last  <= 1'b0;
         end else if (hs) begin
            if (m_last) begin
               state   <= IDLE;
               m_valid <= 1'b0;
            end else begin
               m_data <= sel_ch(hold, ch_nxt);
               m_ch   <= ch_nxt;
               m_last <= (ch_nxt == CH_W'(NUM_CH - 1));
            end
         end
      end
   end

endmodule

// File: tb/tb_channel_serializer.sv
// Directed bench for channel_serializer with a queue-based scoreboard on the output stream.
module tb_channel_serializer;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC*DW-1:0] x_in;
   logic          x_valid;
   logic [DW-1:0] m_data;
   logic [1:0]    m_ch;
   logic          m_last;
   logic          m_valid;
   logic          m_ready;
   logic          overflow;
   logic          clear_overflow;
   logic [2:0]    fifo_level;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  ch;
      logic        last;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   channel_serializer #(
      .DATA_WIDTH (DW),
      .NUM_CH     (NC),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .x_in           (x_in),
      .x_valid        (x_valid),
      .m_data         (m_data),
      .m_ch           (m_ch),
      .m_last         (m_last),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .fifo_level     (fifo_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
      return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
   endfunction

   task automatic expect_vec(input int a0, input int a1, input int a2, input int a3);
      int    a[4];
      beat_t e;
      a = '{a0, a1, a2, a3};
      for (int i = 0; i < 4; i++) begin
         e.d    = 16'(a[i]);
         e.ch   = 2'(i);
         e.last = (i == 3);
         exp_q.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got data %0h ch %0d with nothing expected", m_data, m_ch);
         end else begin
            e = exp_q.pop_front();
            checks--;
            chk("beat_data", 32'(m_data), 32'(e.d));
            chk("beat_ch",   32'(m_ch),   32'(e.ch));
            chk("beat_last", 32'(m_last), 32'(e.last));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0; x_in = '0; x_valid = 1'b0; m_ready = 1'b0; clear_overflow = 1'b0;
      step(); step();
      chk("rst_m_valid",  32'(m_valid),    0);
      chk("rst_m_data",   32'(m_data),     0);
      chk("rst_m_ch",     32'(m_ch),       0);
      chk("rst_m_last",   32'(m_last),     0);
      chk("rst_overflow", 32'(overflow),   0);
      chk("rst_level",    32'(fifo_level), 0);
      rst_n = 1'b1; m_ready = 1'b1;
      step();

      // Single vector, latency and framing
      for (int c = 0; c < 8; c++) begin
         x_valid = (c == 0);
         x_in    = pack4(10, -20, 30, -40);
         if (c == 0) expect_vec(10, -20, 30, -40);
         if (c >= 2 && c <= 5) begin
            chk("t1_valid", 32'(m_valid), 1);
            chk("t1_ch",    32'(m_ch),    32'(c - 2));
            chk("t1_last",  32'(m_last),  32'(c == 5));
         end else begin
            chk("t1_idle_valid", 32'(m_valid), 0);
         end
         step();
      end

      // Back-to-back vectors with no bubble
      for (int c = 0; c < 12; c++) begin
         x_valid = (c == 0 || c == 4);
         x_in    = (c == 0) ? pack4(1000, 1001, 1002, 1003) : pack4(-5, -6, -7, -8);
         if (c == 0) expect_vec(1000, 1001, 1002, 1003);
         if (c == 4) expect_vec(-5, -6, -7, -8);
         chk("t2_level_le1", 32'(fifo_level <= 3'd1), 1);
         if (c >= 2 && c <= 9) chk("t2_valid", 32'(m_valid), 1);
         if (c == 10) chk("t2_end_valid", 32'(m_valid), 0);
         step();
      end

      // Backpressure holds the output register
      for (int c = 0; c < 12; c++) begin
         x_valid = (c == 0);
         x_in    = pack4(1, 2, 3, 4);
         m_ready = !(c >= 3 && c <= 6);
         if (c == 0) expect_vec(1, 2, 3, 4);
         if (c >= 3 && c <= 7) begin
            chk("t3_hold_valid", 32'(m_valid), 1);
            chk("t3_hold_data",  32'(m_data),  2);
            chk("t3_hold_ch",    32'(m_ch),    1);
         end
         if (c == 8) chk("t3_data_ch2", 32'(m_data), 3);
         if (c == 9) chk("t3_last", 32'(m_last), 1);
         if (c == 10) chk("t3_end_valid", 32'(m_valid), 0);
         step();
      end

      // Overflow: one in flight plus FIFO_DEPTH retained, the sixth dropped
      m_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         x_valid = 1'b1;
         x_in    = pack4(100 + c, 200 + c, 300 + c, 400 + c);
         if (c < 5) expect_vec(100 + c, 200 + c, 300 + c, 400 + c);
         step();
      end
      x_valid = 1'b0;
      chk("t4_level_full", 32'(fifo_level), 4);
      chk("t4_overflow",   32'(overflow),   1);
      chk("t4_head_data",  32'(m_data),     100);
      x_valid = 1'b1; x_in = pack4(999, 999, 999, 999); clear_overflow = 1'b1;
      step();
      x_valid = 1'b0; clear_overflow = 1'b0;
      chk("t4_set_wins",   32'(overflow),   1);
      chk("t4_level_hold", 32'(fifo_level), 4);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      chk("t4_cleared", 32'(overflow), 0);

      // Full FIFO accepts a vector arriving with the last-beat handshake
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            chk("t5_last_beat", 32'(m_last), 1);
            x_valid = 1'b1;
            x_in    = pack4(106, 206, 306, 406);
            expect_vec(106, 206, 306, 406);
         end
         step();
      end
      x_valid = 1'b0;
      chk("t5_level_stays", 32'(fifo_level), 4);
      chk("t5_no_overflow", 32'(overflow),   0);
      n = 0;
      while ((m_valid !== 1'b0 || fifo_level !== 3'd0) && n < 60) begin
         step();
         n++;
      end
      chk("t5_drain_bound", 32'(n < 60), 1);
      chk("t5_queue_empty", 32'(exp_q.size()), 0);

      // Reset mid-vector discards everything in flight
      x_valid = 1'b1; x_in = pack4(50, 51, 52, 53); expect_vec(50, 51, 52, 53);
      step();
      x_valid = 1'b1; x_in = pack4(60, 61, 62, 63); expect_vec(60, 61, 62, 63);
      step();
      x_valid = 1'b0;
      step();
      chk("t6_ch1_shown", 32'(m_ch), 1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_rst_valid",    32'(m_valid),    0);
      chk("t6_rst_level",    32'(fifo_level), 0);
      chk("t6_rst_overflow", 32'(overflow),   0);
      exp_q.delete();
      x_valid = 1'b1; x_in = pack4(7, 8, 9, 10); expect_vec(7, 8, 9, 10);
      step();
      x_valid = 1'b0;
      chk("t6_lat_valid", 32'(m_valid), 0);
      step();
      chk("t6_first_valid", 32'(m_valid), 1);
      chk("t6_first_ch",    32'(m_ch),    0);
      chk("t6_first_data",  32'(m_data),  7);
      n = 0;
      while (m_valid !== 1'b0 && n < 20) begin
         step();
         n++;
      end
      chk("t6_drain_bound", 32'(n < 20), 1);
      chk("t6_queue_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
